// File: rtl/return_stack_ctrl_pkg.sv
// rtl/return_stack_ctrl_pkg.sv - shared constants, stack op encoding and decode helpers
package return_stack_ctrl_pkg;

   localparam int ADDR_W_DEFAULT = 12;
   localparam int DEPTH_DEFAULT  = 8;

   // Instruction prefixes the controller decodes into push (call) and pop (return)
   localparam logic [4:0] CALL_PREFIX = 5'b11101;
   localparam logic [5:0] RET_PREFIX  = 6'b111100;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_REPL = 2'b11
   } stack_op_e;

   function automatic stack_op_e decode_op(input logic push, input logic pop);
      return stack_op_e'({pop, push});
   endfunction

   function automatic logic is_call_prefix(input logic [4:0] prefix);
      return prefix == CALL_PREFIX;
   endfunction

   function automatic logic is_ret_prefix(input logic [5:0] prefix);
      return prefix == RET_PREFIX;
   endfunction

endpackage

// File: rtl/return_stack_ctrl_if.sv
// rtl/return_stack_ctrl_if.sv - controller <-> return stack signal bundle
interface return_stack_ctrl_if #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 12
) ();
   localparam int PTR_W = $clog2(DEPTH);

   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] push_addr;
   logic [ADDR_W-1:0] top_addr;
   logic [PTR_W:0]    count;
   logic              empty;
   logic              full;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, pop, push_addr,
      input  top_addr, count, empty, full, overflow, underflow
   );

   modport slave (
      input  push, pop, push_addr,
      output top_addr, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/ret_stack_mem.sv
// rtl/ret_stack_mem.sv - DEPTH x ADDR_W register file, one sync write port, one async read port
module ret_stack_mem #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 12,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_idx,
   input  logic [ADDR_W-1:0] wr_data,
   input  logic [PTR_W-1:0]  rd_idx,
   output logic [ADDR_W-1:0] rd_data
);
   logic [ADDR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/return_stack_ctrl.sv
// rtl/return_stack_ctrl.sv - return-address stack: pointer, occupancy count, sticky error flags
module return_stack_ctrl
   import return_stack_ctrl_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic                clock,
   input  logic                init_signal,
   return_stack_ctrl_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] SP_ONE   = PTR_W'(1);

   logic [PTR_W-1:0]  sp_q, sp_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;
   logic [ADDR_W-1:0] rd_data;
   logic              is_empty, is_full;
   stack_op_e         op;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);
   assign op       = decode_op(bus.push, bus.pop);

   always_comb begin
      sp_d        = sp_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      wr_en       = 1'b0;
      wr_idx      = sp_q;
      case (op)
         OP_PUSH: begin
            if (is_full) begin
               overflow_d = 1'b1;
            end else begin
               wr_en   = 1'b1;
               sp_d    = sp_q + SP_ONE;
               count_d = count_q + CNT_ONE;
            end
         end
         OP_POP: begin
            if (is_empty) begin
               underflow_d = 1'b1;
            end else begin
               sp_d    = sp_q - SP_ONE;
               count_d = count_q - CNT_ONE;
            end
         end
         OP_REPL: begin
            // Replace-top overwrites in place; on an empty stack it degrades to a push
            wr_en = 1'b1;
            if (is_empty) begin
               sp_d        = sp_q + SP_ONE;
               count_d     = count_q + CNT_ONE;
               underflow_d = 1'b1;
            end else begin
               wr_idx = sp_q - SP_ONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (init_signal) begin
         sp_q        <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   ret_stack_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clock   (clock),
      .wr_en   (wr_en && !init_signal),
      .wr_idx  (wr_idx),
      .wr_data (bus.push_addr),
      .rd_idx  (sp_q - SP_ONE),
      .rd_data (rd_data)
   );

   assign bus.top_addr  = is_empty ? '0 : rd_data;
   assign bus.count     = count_q;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_return_stack_ctrl.sv
// tb/tb_return_stack_ctrl.sv - table-driven, scoreboarded bench for return_stack_ctrl
module tb_return_stack_ctrl;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 12;

   typedef struct {
      logic        rst;
      logic        push;
      logic        pop;
      logic [11:0] addr;
      logic [11:0] top_now;
      logic [3:0]  cnt;
      logic        emp;
      logic        ful;
      logic        ovf;
      logic        unf;
      logic [11:0] top_nxt;
   } vec_t;

   typedef struct {
      string       name;
      logic [3:0]  cnt;
      logic        emp;
      logic        ful;
      logic        ovf;
      logic        unf;
      logic [11:0] top;
   } exp_t;

   logic clock = 1'b0;
   logic init_signal;
   int   tests = 0;
   int   failed = 0;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clock = ~clock;

   return_stack_ctrl_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

   return_stack_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock       (clock),
      .init_signal (init_signal),
      .bus         (bus)
   );

   function automatic vec_t v(input logic rst, input logic push, input logic pop,
                              input logic [11:0] addr, input logic [11:0] top_now,
                              input logic [3:0] cnt, input logic emp, input logic ful,
                              input logic ovf, input logic unf, input logic [11:0] top_nxt);
      vec_t r;
      r.rst = rst; r.push = push; r.pop = pop; r.addr = addr; r.top_now = top_now;
      r.cnt = cnt; r.emp = emp; r.ful = ful; r.ovf = ovf; r.unf = unf; r.top_nxt = top_nxt;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      init_signal   = 1'b1;
      bus.push      = 1'b0;
      bus.pop       = 1'b0;
      bus.push_addr = '0;

      // reset, idle, simple LIFO
      vecs.push_back(v(1, 0, 0, 12'h000, 12'h000, 0, 1, 0, 0, 0, 12'h000));
      for (int i = 0; i < 3; i++)
         vecs.push_back(v(0, 0, 0, 12'h000, 12'h000, 0, 1, 0, 0, 0, 12'h000));
      vecs.push_back(v(0, 1, 0, 12'h010, 12'h000, 1, 0, 0, 0, 0, 12'h010));
      vecs.push_back(v(0, 1, 0, 12'h020, 12'h010, 2, 0, 0, 0, 0, 12'h020));
      vecs.push_back(v(0, 1, 0, 12'h030, 12'h020, 3, 0, 0, 0, 0, 12'h030));
      vecs.push_back(v(0, 0, 1, 12'h000, 12'h030, 2, 0, 0, 0, 0, 12'h020));
      vecs.push_back(v(0, 0, 1, 12'h000, 12'h020, 1, 0, 0, 0, 0, 12'h010));
      vecs.push_back(v(0, 0, 1, 12'h000, 12'h010, 0, 1, 0, 0, 0, 12'h000));
      // fill to full, overflow, drain
      for (int k = 0; k < 8; k++)
         vecs.push_back(v(0, 1, 0, 12'h100 + 12'(k), (k == 0) ? 12'h000 : 12'h0FF + 12'(k),
                          4'(k + 1), 0, (k == 7), 0, 0, 12'h100 + 12'(k)));
      vecs.push_back(v(0, 1, 0, 12'h108, 12'h107, 8, 0, 1, 1, 0, 12'h107));
      for (int k = 0; k < 8; k++)
         vecs.push_back(v(0, 0, 1, 12'h000, 12'h107 - 12'(k), 4'(7 - k), (k == 7), 0, 1, 0,
                          (k == 7) ? 12'h000 : 12'h106 - 12'(k)));
      // underflow is sticky, stack still usable
      vecs.push_back(v(0, 0, 1, 12'h000, 12'h000, 0, 1, 0, 1, 1, 12'h000));
      vecs.push_back(v(0, 1, 0, 12'h055, 12'h000, 1, 0, 0, 1, 1, 12'h055));
      vecs.push_back(v(1, 0, 0, 12'h000, 12'h055, 0, 1, 0, 0, 0, 12'h000));
      // replace-top, then push+pop on empty
      vecs.push_back(v(0, 1, 0, 12'h0AA, 12'h000, 1, 0, 0, 0, 0, 12'h0AA));
      vecs.push_back(v(0, 1, 1, 12'h0BB, 12'h0AA, 1, 0, 0, 0, 0, 12'h0BB));
      vecs.push_back(v(0, 0, 1, 12'h000, 12'h0BB, 0, 1, 0, 0, 0, 12'h000));
      vecs.push_back(v(0, 1, 1, 12'h0CC, 12'h000, 1, 0, 0, 0, 1, 12'h0CC));
      // reset beats a simultaneous push
      vecs.push_back(v(0, 1, 0, 12'h011, 12'h0CC, 2, 0, 0, 0, 1, 12'h011));
      vecs.push_back(v(0, 1, 0, 12'h022, 12'h011, 3, 0, 0, 0, 1, 12'h022));
      vecs.push_back(v(1, 1, 0, 12'h033, 12'h022, 0, 1, 0, 0, 0, 12'h000));
      vecs.push_back(v(0, 0, 0, 12'h000, 12'h000, 0, 1, 0, 0, 0, 12'h000));
      // replace-top while full leaves flags alone
      for (int k = 0; k < 8; k++)
         vecs.push_back(v(0, 1, 0, 12'h200 + 12'(k), (k == 0) ? 12'h000 : 12'h1FF + 12'(k),
                          4'(k + 1), 0, (k == 7), 0, 0, 12'h200 + 12'(k)));
      vecs.push_back(v(0, 1, 1, 12'h2FF, 12'h207, 8, 0, 1, 0, 0, 12'h2FF));
      vecs.push_back(v(0, 0, 1, 12'h000, 12'h2FF, 7, 0, 0, 0, 0, 12'h206));
      vecs.push_back(v(0, 0, 1, 12'h000, 12'h206, 6, 0, 0, 0, 0, 12'h205));

      @(posedge clock);
      #1;
      init_signal = 1'b0;

      foreach (vecs[i]) begin
         exp_t e;
         init_signal   = vecs[i].rst;
         bus.push      = vecs[i].push;
         bus.pop       = vecs[i].pop;
         bus.push_addr = vecs[i].addr;
         e.name = $sformatf("v%0d", i);
         e.cnt  = vecs[i].cnt;
         e.emp  = vecs[i].emp;
         e.ful  = vecs[i].ful;
         e.ovf  = vecs[i].ovf;
         e.unf  = vecs[i].unf;
         e.top  = vecs[i].top_nxt;
         sb.push_back(e);
         #1;
         check($sformatf("v%0d top_same_cycle", i), 32'(bus.top_addr), 32'(vecs[i].top_now));
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, " count"},     32'(bus.count),     32'(e.cnt));
            check({e.name, " empty"},     32'(bus.empty),     32'(e.emp));
            check({e.name, " full"},      32'(bus.full),      32'(e.ful));
            check({e.name, " overflow"},  32'(bus.overflow),  32'(e.ovf));
            check({e.name, " underflow"}, 32'(bus.underflow), 32'(e.unf));
            check({e.name, " top_next"},  32'(bus.top_addr),  32'(e.top));
         end
      end
      init_signal = 1'b0;
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/return_stack_ctrl.md
Name: return_stack_ctrl

Overview:
- Hardware return-address stack serving the controller's push/pop/RET signals.
- Stores return addresses (PC+1) on a subroutine call (push) and presents the top entry as the next PC on return (pop).
- Sits between the instruction controller and the PC-select mux. top_addr feeds the RET input of that mux.
- Tracks occupancy and flags overflow/underflow so software errors are visible and never corrupt stored entries.

Parameters:
- DEPTH, 8, number of stack entries (power of two, 2..64).
- ADDR_W, 12, return-address width; matches the 12-bit instruction address field.
- PTR_W, $clog2(DEPTH), stack-pointer width.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- init_signal  input  1  synchronous active-high reset.
- push  input  1  call in this cycle; store push_addr.
- pop  input  1  return in this cycle; consume top entry.
- push_addr  input  ADDR_W  return address to store (PC+1).
- top_addr  output  ADDR_W  current top entry; 0 when empty.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set on a rejected push.
- underflow  output  1  sticky; set on a rejected pop.

Behaviour:
- Reset, synchronous (init_signal high at a rising edge):
  - sp=0, count=0, overflow=0, underflow=0; empty=1, full=0, top_addr=0.
  - Storage contents are not cleared.
  - Reset wins over a push or pop in the same cycle.
- top_addr is combinational from mem[sp-1], gated to 0 when empty. The controller samples it in the same cycle pop is high (zero-latency RET).
- Push only, not full: mem[sp] <= push_addr, sp++, count++. The new top is visible on top_addr the next cycle.
- Push only, full: no write, sp and count unchanged, overflow <= 1. Existing entries are preserved.
- Pop only, not empty: sp--, count--. top_addr shows the entry below the next cycle.
- Pop only, empty: no change, underflow <= 1, top_addr stays 0.
- Push and pop together, not empty (including full): replace-top.
  - mem[sp-1] <= push_addr; sp and count unchanged.
  - top_addr this cycle still shows the old top; next cycle it shows push_addr.
  - No flag change.
- Push and pop together, empty: treated as push only (write mem[0], count=1), and underflow <= 1.
- sp wraps modulo DEPTH internally. count is a separate PTR_W+1 counter so that full and empty are distinguishable.
- Sticky flags clear only on reset.
- No handshake stall: the block accepts one operation per cycle unconditionally.
- Outputs empty, full and count are registered-state derived, with no glitch path from the inputs.

Decomposition:
- Shared package (ctrl_pkg):
  - ADDR_W default 12.
  - Opcode prefix constants used to derive push/pop: 5'b11101 call, 6'b111100 return.
  - Stack op encoding: OP_NONE, OP_PUSH, OP_POP, OP_REPL as a 2-bit enum.
- Sub-module ret_stack_mem: DEPTH x ADDR_W register file with one synchronous write port and one asynchronous read port.
- return_stack_ctrl owns the pointer, the count, the flags and op decoding.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, top_addr=0, overflow=0, underflow=0.
- Push 0x010, 0x020, 0x030 on consecutive cycles, then pop x3 -> top_addr reads 0x030, 0x020, 0x010 in the pop cycles; final count=0, empty=1.
- Push 9 values 0x100..0x108 with DEPTH=8:
  - After 8 pushes full=1.
  - The 9th push sets overflow=1 and count stays 8.
  - Popping all 8 returns 0x107..0x100; 0x108 never appears.
- Pop on empty -> underflow=1, count=0. Then push 0x055 -> count=1, top_addr=0x055, underflow still 1.
- Push 0x0AA, then push+pop together with push_addr=0x0BB:
  - In that cycle top_addr=0x0AA.
  - Next cycle top_addr=0x0BB, count=1.
- Push 0x011 and 0x022, then assert init_signal together with push 0x033 -> next cycle count=0, empty=1, top_addr=0, both flags 0.
